wam_btn: RTL and testbench

//   Input conditioner for the push buttons (clr, lft, rgt). Sits directly

---
 rtl/wam_btn.sv | 144 ++++++++++++++
 tb/tb_wam_btn.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wam_btn.sv
// Push-button conditioner: synchroniser, debounce filter and
// press/release/auto-repeat strobes for each button.
module wam_btn #(
    parameter int                 NBTN    = 3,
    parameter int                 DEB_CNT = 65536,
    parameter int                 REP_DLY = 2**24,
    parameter int                 REP_PER = 2**22,
    parameter logic [NBTN-1:0]    REP_EN  = 3'b110,
    parameter int                 CW      = 25
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] lvl,
    output logic [NBTN-1:0] pls,
    output logic [NBTN-1:0] rel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        RPT  = 2'd2
    } st_t;

    logic [NBTN-1:0] s1;
    logic [NBTN-1:0] s2;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        st_t           st;
        st_t           st_nxt;
        logic [CW-1:0] deb_cnt;
        logic [CW-1:0] rep_cnt;
        logic [CW-1:0] rep_nxt;
        logic          lvl_q;
        logic          pls_q;
        logic          rel_q;
        logic          pls_d;
        logic          rel_d;
        logic          tog;
        logic          rise;
        logic          fall;

        assign tog  = (s2[i] != lvl_q) && (deb_cnt == CW'(DEB_CNT - 1));
        assign rise = tog && !lvl_q;
        assign fall = tog && lvl_q;

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                deb_cnt <= '0;
                lvl_q   <= 1'b0;
            end else if (s2[i] == lvl_q) begin
                deb_cnt <= '0;
            end else if (tog) begin
                deb_cnt <= '0;
                lvl_q   <= ~lvl_q;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                st      <= IDLE;
                rep_cnt <= '0;
                pls_q   <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                st      <= st_nxt;
                rep_cnt <= rep_nxt;
                pls_q   <= pls_d;
                rel_q   <= rel_d;
            end
        end

        always_comb begin
            st_nxt = st;
            unique case (st)
                IDLE: if (rise) st_nxt = HELD;
                HELD: begin
                    if (fall)
                        st_nxt = IDLE;
                    else if (REP_EN[i] &&
                             rep_cnt == CW'(REP_DLY - 1))
                        st_nxt = RPT;
                end
                RPT:  if (fall) st_nxt = IDLE;
                default: st_nxt = IDLE;
            endcase
        end

        // Release wins over a repeat that falls due in the same cycle.
        always_comb begin
            pls_d   = 1'b0;
            rel_d   = 1'b0;
            rep_nxt = rep_cnt;
            unique case (st)
                IDLE: begin
                    rep_nxt = '0;
                    pls_d   = rise;
                end
                HELD: begin
                    if (fall) begin
                        rel_d   = 1'b1;
                        rep_nxt = '0;
                    end else if (rep_cnt == CW'(REP_DLY - 1)) begin
                        if (REP_EN[i]) begin
                            pls_d   = 1'b1;
                            rep_nxt = '0;
                        end
                    end else begin
                        rep_nxt = rep_cnt + CW'(1);
                    end
                end
                RPT: begin
                    if (fall) begin
                        rel_d   = 1'b1;
                        rep_nxt = '0;
                    end else if (rep_cnt == CW'(REP_PER - 1)) begin
                        pls_d   = 1'b1;
                        rep_nxt = '0;
                    end else begin
                        rep_nxt = rep_cnt + CW'(1);
                    end
                end
                default: rep_nxt = '0;
            endcase
        end

        assign lvl[i] = lvl_q;
        assign pls[i] = pls_q;
        assign rel[i] = rel_q;
    end

endmodule

// File: tb/tb_wam_btn.sv
// Scoreboard bench for wam_btn: stimulus queues expected strobes,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_wam_btn;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic       clk;
    logic       clr_n;
    logic [2:0] btn;
    logic [2:0] lvl;
    logic [2:0] pls;
    logic [2:0] rel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         c;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] l;
    } exp_t;

    exp_t q[$];

    wam_btn #(
        .NBTN   (3),
        .DEB_CNT(DEB),
        .REP_DLY(DLY),
        .REP_PER(PER),
        .REP_EN (3'b110),
        .CW     (8)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .btn  (btn),
        .lvl  (lvl),
        .pls  (pls),
        .rel  (rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [2:0] p,
                        input logic [2:0] r, input logic [2:0] l);
        exp_t e;
        e.c = c;
        e.p = p;
        e.r = r;
        e.l = l;
        q.push_back(e);
    endtask

    // Monitor: zero outputs under reset, otherwise match each strobe.
    always @(negedge clk) begin
        if (!clr_n) begin
            checks++;
            if ({lvl, pls, rel} !== 9'd0) begin
                errors++;
                $display("FAIL reset cyc=%0d lvl=%b pls=%b rel=%b want 0",
                         cyc, lvl, pls, rel);
            end
        end else if ((pls | rel) !== 3'b000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected cyc=%0d pls=%b rel=%b lvl=%b",
                         cyc, pls, rel, lvl);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.c != cyc || e.p !== pls || e.r !== rel ||
                    e.l !== lvl) begin
                    errors++;
                    $display({"FAIL event got cyc=%0d pls=%b rel=%b ",
                              "lvl=%b want cyc=%0d pls=%b rel=%b lvl=%b"},
                             cyc, pls, rel, lvl, e.c, e.p, e.r, e.l);
                end
            end
        end
    end

    initial begin
        int n;
        int t;
        btn   = 3'b000;
        clr_n = 1'b0;

        // Inputs toggling under reset must not reach the outputs.
        step(2); btn = 3'b111;
        step(6); btn = 3'b010;
        step(2); btn = 3'b000;
        step(2); clr_n = 1'b1;
        step(10);

        // btn[1]: press, delayed repeat, periodic repeats, release.
        // The release lands where a repeat would be due.
        n = cyc;
        push(n + DEB + 2, 3'b010, 3'b000, 3'b010);
        t = n + DEB + 2 + DLY;
        while (t < n + 40 + DEB + 2) begin
            push(t, 3'b010, 3'b000, 3'b010);
            t += PER;
        end
        push(n + 40 + DEB + 2, 3'b000, 3'b010, 3'b000);
        btn[1] = 1'b1; step(40);
        btn[1] = 1'b0; step(12);

        // btn[2] bounce: short highs are filtered out.
        btn[2] = 1'b1; step(3);
        btn[2] = 1'b0; step(1);
        btn[2] = 1'b1; step(3);
        btn[2] = 1'b0; step(10);
        n = cyc;
        push(n + 6, 3'b100, 3'b000, 3'b100);
        push(n + 14, 3'b000, 3'b100, 3'b000);
        btn[2] = 1'b1; step(8);
        btn[2] = 1'b0; step(12);

        // btn[0] never repeats.
        n = cyc;
        push(n + 6, 3'b001, 3'b000, 3'b001);
        push(n + 46, 3'b000, 3'b001, 3'b000);
        btn[0] = 1'b1; step(40);
        btn[0] = 1'b0; step(12);

        // Simultaneous press, then reset with btn[2] in repeat.
        n = cyc;
        push(n + 6, 3'b101, 3'b000, 3'b101);
        push(n + 16, 3'b100, 3'b000, 3'b101);
        push(n + 19, 3'b100, 3'b000, 3'b101);
        btn = 3'b101; step(20);
        @(posedge clk); #2 clr_n = 1'b0;
        step(3);

        // Held through reset release: fresh press afterwards.
        clr_n = 1'b1;
        n = cyc;
        push(n + 6, 3'b101, 3'b000, 3'b101);
        push(n + 16, 3'b100, 3'b000, 3'b101);
        push(n + 18, 3'b000, 3'b101, 3'b000);
        step(12);
        btn = 3'b000; step(15);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending got %0d outstanding want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
